// File: rtl/tx_frame_arbiter_if.sv
// -----------------------------------------------------------------------------
// tx_frame_arbiter_if
// Result and UART-side signals of the TX frame arbiter, bundled for port use.
//
// Signals:
//   rf_data  / rf_vld   register-file read data and its one-cycle valid pulse
//   alu_data / alu_vld  ALU result (two bytes) and its one-cycle valid pulse
//   tx_busy             UART TX busy, already synchronized to the REF clock
//   tx_data  / tx_vld   byte and one-cycle valid toward the TX data synchronizer
//   arb_busy            a result is pending or a frame is in progress
//   drop_err            one-cycle pulse when an incoming result is discarded
//
// Modports:
//   slave   the arbiter itself
//   master  the controller/UART side driving results and busy
// -----------------------------------------------------------------------------
interface tx_frame_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]   rf_data;
    logic                    rf_vld;
    logic [2*DATA_WIDTH-1:0] alu_data;
    logic                    alu_vld;
    logic                    tx_busy;
    logic [DATA_WIDTH-1:0]   tx_data;
    logic                    tx_vld;
    logic                    arb_busy;
    logic                    drop_err;

    modport slave (
        input  rf_data,
        input  rf_vld,
        input  alu_data,
        input  alu_vld,
        input  tx_busy,
        output tx_data,
        output tx_vld,
        output arb_busy,
        output drop_err
    );

    modport master (
        output rf_data,
        output rf_vld,
        output alu_data,
        output alu_vld,
        output tx_busy,
        input  tx_data,
        input  tx_vld,
        input  arb_busy,
        input  drop_err
    );
endinterface

// File: rtl/tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tx_frame_arbiter
// Shares the single UART TX path between register-file read results (1 byte)
// and ALU results (2 bytes). Each requester has a one-entry holding register;
// pending results are granted round-robin, serialised LSB first into byte
// transfers and paced on the synchronized UART busy flag. A byte that is not
// acknowledged by busy within ACK_TIMEOUT cycles is re-issued.
//
// Optional build macro:
//   TX_FRAME_CHECKSUM_EN  append one XOR-of-data checksum byte to every frame
//
// Parameters:
//   DATA_WIDTH   width of one UART byte and of register-file data
//   ACK_TIMEOUT  cycles to wait for busy after issuing a byte (minimum 4)
//
// Ports:
//   CLK  REF-domain clock
//   RST  synchronous reset, active-high
//   bus  tx_frame_arbiter_if.slave (results in, bytes out, status)
// -----------------------------------------------------------------------------
module tx_frame_arbiter #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    tx_frame_arbiter_if.slave bus
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned LEFT_W = 2;

`ifdef TX_FRAME_CHECKSUM_EN
    localparam int unsigned REST_BYTES = 2;
    localparam logic [LEFT_W-1:0] RF_LEFT  = 2'd1;
    localparam logic [LEFT_W-1:0] ALU_LEFT = 2'd2;
`else
    localparam int unsigned REST_BYTES = 1;
    localparam logic [LEFT_W-1:0] RF_LEFT  = 2'd0;
    localparam logic [LEFT_W-1:0] ALU_LEFT = 2'd1;
`endif

    localparam int unsigned REST_W = REST_BYTES * DW;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    // State and datapath registers
    logic [1:0]        state_q,    state_d;
    logic [DW-1:0]     rf_hold_q,  rf_hold_d;
    logic              rf_pend_q,  rf_pend_d;
    logic [2*DW-1:0]   alu_hold_q, alu_hold_d;
    logic              alu_pend_q, alu_pend_d;
    logic              ptr_q,      ptr_d;      // 0: RF favoured, 1: ALU favoured
    logic [REST_W-1:0] rest_q,     rest_d;     // bytes still to send, next in LSB
    logic [LEFT_W-1:0] left_q,     left_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [DW-1:0]     tx_data_q,  tx_data_d;
    logic              tx_vld_q,   tx_vld_d;
    logic              arb_busy_q, arb_busy_d;
    logic              drop_err_q, drop_err_d;

    logic              grant_rf;
    logic              grant_alu;
    logic [REST_W-1:0] rf_rest;
    logic [REST_W-1:0] alu_rest;

    // Trailing bytes loaded into the frame shift register at grant time
`ifdef TX_FRAME_CHECKSUM_EN
    assign rf_rest  = {DW'(0), rf_hold_q};
    assign alu_rest = {alu_hold_q[DW-1:0] ^ alu_hold_q[2*DW-1:DW], alu_hold_q[2*DW-1:DW]};
`else
    assign rf_rest  = '0;
    assign alu_rest = alu_hold_q[2*DW-1:DW];
`endif

    // State register and all registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            rf_hold_q  <= '0;
            rf_pend_q  <= 1'b0;
            alu_hold_q <= '0;
            alu_pend_q <= 1'b0;
            ptr_q      <= 1'b0;
            rest_q     <= '0;
            left_q     <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_vld_q   <= 1'b0;
            arb_busy_q <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_hold_q  <= rf_hold_d;
            rf_pend_q  <= rf_pend_d;
            alu_hold_q <= alu_hold_d;
            alu_pend_q <= alu_pend_d;
            ptr_q      <= ptr_d;
            rest_q     <= rest_d;
            left_q     <= left_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_vld_q   <= tx_vld_d;
            arb_busy_q <= arb_busy_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Next-state, arbitration, capture and output-next logic
    always_comb begin
        state_d    = state_q;
        rf_hold_d  = rf_hold_q;
        rf_pend_d  = rf_pend_q;
        alu_hold_d = alu_hold_q;
        alu_pend_d = alu_pend_q;
        ptr_d      = ptr_q;
        rest_d     = rest_q;
        left_d     = left_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_vld_d   = 1'b0;
        arb_busy_d = 1'b0;
        drop_err_d = 1'b0;
        grant_rf   = 1'b0;
        grant_alu  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rf_pend_q && (!alu_pend_q || !ptr_q)) begin
                    grant_rf = 1'b1;
                end else if (alu_pend_q) begin
                    grant_alu = 1'b1;
                end
                // Pointer only moves when both sides actually contend
                if (rf_pend_q && alu_pend_q) begin
                    ptr_d = ~ptr_q;
                end
                if (grant_rf) begin
                    tx_data_d = rf_hold_q;
                    rest_d    = rf_rest;
                    left_d    = RF_LEFT;
                    cnt_d     = '0;
                    state_d   = ST_ISSUE;
                end else if (grant_alu) begin
                    tx_data_d = alu_hold_q[DW-1:0];
                    rest_d    = alu_rest;
                    left_d    = ALU_LEFT;
                    cnt_d     = '0;
                    state_d   = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // No acknowledge: re-issue the byte still held in tx_data
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (left_q != '0) begin
                        tx_data_d = rest_q[DW-1:0];
                        rest_d    = rest_q >> DW;
                        left_d    = left_q - LEFT_W'(1);
                        cnt_d     = '0;
                        state_d   = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A grant frees its holder in the same cycle, so a coincident vld is kept
        if (grant_rf) begin
            rf_pend_d = 1'b0;
        end
        if (bus.rf_vld) begin
            if (!rf_pend_q || grant_rf) begin
                rf_hold_d = bus.rf_data;
                rf_pend_d = 1'b1;
            end else begin
                drop_err_d = 1'b1;
            end
        end

        if (grant_alu) begin
            alu_pend_d = 1'b0;
        end
        if (bus.alu_vld) begin
            if (!alu_pend_q || grant_alu) begin
                alu_hold_d = bus.alu_data;
                alu_pend_d = 1'b1;
            end else begin
                drop_err_d = 1'b1;
            end
        end

        tx_vld_d   = (state_d == ST_ISSUE);
        arb_busy_d = rf_pend_d | alu_pend_d | (state_d != ST_IDLE);
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_vld   = tx_vld_q;
    assign bus.arb_busy = arb_busy_q;
    assign bus.drop_err = drop_err_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_frame_arbiter
// Scoreboard bench for tx_frame_arbiter: directed result posts push the
// expected byte stream into a queue, a monitor pops and compares on tx_vld.
// A simple UART model raises busy 3 cycles after each byte for 10 cycles.
// -----------------------------------------------------------------------------
module tb_tx_frame_arbiter;

    localparam int unsigned DW    = 8;
    localparam int unsigned ACKTO = 8;

    logic clk;
    logic rst;

    tx_frame_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    tx_frame_arbiter #(
        .DATA_WIDTH  (DW),
        .ACK_TIMEOUT (ACKTO)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [7:0]  exp_q[$];
    int          drop_q[$];
    int          vld_cyc_q[$];
    int          drop_cnt    = 0;
    int          busy_fall_cyc = -1;
    int          arb_fall_cyc  = -1;
    logic        ack_en        = 1'b1;

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART model: busy rises 3 cycles after a byte and stays high 10 cycles
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_vld && ack_en) begin
                repeat (3) @(posedge clk);
                #1 bus.tx_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    // Monitor: scoreboard compare of bytes and drop pulses, edge tracking
    initial begin
        logic [7:0] e;
        logic       prev_busy = 1'b0;
        logic       prev_arb  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_vld) begin
                vld_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_byte: unexpected tx_vld data=%02h, none expected (cycle %0d)",
                             bus.tx_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 32'(bus.tx_data), 32'(e));
                end
            end
            if (bus.drop_err) begin
                drop_cnt++;
                if (drop_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL drop_err: unexpected pulse at cycle %0d, none expected", cyc);
                end else begin
                    check("drop_err_cycle", 32'(cyc), 32'(drop_q.pop_front()));
                end
            end
            if (prev_busy && !bus.tx_busy)  busy_fall_cyc = cyc;
            if (prev_arb  && !bus.arb_busy) arb_fall_cyc  = cyc;
            prev_busy = bus.tx_busy;
            prev_arb  = bus.arb_busy;
        end
    end

    // Input drivers: called 1 ns after a rising edge, return 1 ns after the next
    task automatic pulse_rf(input logic [7:0] d);
        bus.rf_data = d;
        bus.rf_vld  = 1'b1;
        @(posedge clk); #1;
        bus.rf_vld  = 1'b0;
    endtask

    task automatic pulse_alu(input logic [15:0] d);
        bus.alu_data = d;
        bus.alu_vld  = 1'b1;
        @(posedge clk); #1;
        bus.alu_vld  = 1'b0;
    endtask

    task automatic pulse_both(input logic [7:0] r, input logic [15:0] a);
        bus.rf_data  = r;
        bus.alu_data = a;
        bus.rf_vld   = 1'b1;
        bus.alu_vld  = 1'b1;
        @(posedge clk); #1;
        bus.rf_vld   = 1'b0;
        bus.alu_vld  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || bus.arb_busy) && n < 3000);
        check(name, 32'(exp_q.size() == 0 && !bus.arb_busy), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_data"},  32'(bus.tx_data),  32'd0);
        check({tag, "_tx_vld"},   32'(bus.tx_vld),   32'd0);
        check({tag, "_arb_busy"}, 32'(bus.arb_busy), 32'd0);
        check({tag, "_drop_err"}, 32'(bus.drop_err), 32'd0);
    endtask

    initial begin
        int n;
        int a;
        int guard;

        rst          = 1'b1;
        bus.rf_data  = '0;
        bus.rf_vld   = 1'b0;
        bus.alu_data = '0;
        bus.alu_vld  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single RF byte: latency n+2, arb_busy drops the cycle after busy falls
        vld_cyc_q.delete();
        n = cyc;
        exp_q.push_back(8'hA5);
`ifdef TX_FRAME_CHECKSUM_EN
        exp_q.push_back(8'hA5);
`endif
        pulse_rf(8'hA5);
        wait_idle("rf_frame_done");
        check("rf_latency", 32'(vld_cyc_q[0]), 32'(n + 2));
        check("arb_busy_fall", 32'(arb_fall_cyc), 32'(busy_fall_cyc + 1));

        // ALU frame: LSB first, second byte one cycle after busy is seen low
        vld_cyc_q.delete();
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
`ifdef TX_FRAME_CHECKSUM_EN
        exp_q.push_back(8'h26);
`endif
        pulse_alu(16'h1234);
        wait_idle("alu_frame_done");
        check("alu_byte_spacing", 32'(vld_cyc_q[1] - vld_cyc_q[0]), 32'd14);

        // Simultaneous posts: RF wins first, pointer then favours ALU
        exp_q.push_back(8'h11);
`ifdef TX_FRAME_CHECKSUM_EN
        exp_q.push_back(8'h11);
`endif
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
`ifdef TX_FRAME_CHECKSUM_EN
        exp_q.push_back(8'h51);
`endif
        pulse_both(8'h11, 16'hBEEF);
        wait_idle("contend1_done");

        exp_q.push_back(8'h78);
        exp_q.push_back(8'h56);
`ifdef TX_FRAME_CHECKSUM_EN
        exp_q.push_back(8'h2E);
`endif
        exp_q.push_back(8'h22);
`ifdef TX_FRAME_CHECKSUM_EN
        exp_q.push_back(8'h22);
`endif
        pulse_both(8'h22, 16'h5678);
        wait_idle("contend2_done");

        // Second RF post while RF is still held behind an ALU frame is dropped
        drop_cnt = 0;
        a = cyc;
        drop_q.push_back(a + 4);
        exp_q.push_back(8'h9B);
        exp_q.push_back(8'h9A);
`ifdef TX_FRAME_CHECKSUM_EN
        exp_q.push_back(8'h01);
`endif
        exp_q.push_back(8'h33);
`ifdef TX_FRAME_CHECKSUM_EN
        exp_q.push_back(8'h33);
`endif
        pulse_alu(16'h9A9B);
        pulse_rf(8'h33);
        @(posedge clk); #1;
        pulse_rf(8'h44);
        wait_idle("drop_frame_done");
        check("drop_pulse_count", 32'(drop_cnt), 32'd1);
        check("drop_q_empty", 32'(drop_q.size()), 32'd0);

        // No acknowledge: same byte re-issued every ACKTO+1 cycles
        ack_en = 1'b0;
        vld_cyc_q.delete();
        repeat (3) exp_q.push_back(8'h5A);
        pulse_rf(8'h5A);
        guard = 0;
        while (vld_cyc_q.size() < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("retry_seen", 32'(vld_cyc_q.size() >= 3), 32'd1);
        if (vld_cyc_q.size() >= 3) begin
            check("retry_period1", 32'(vld_cyc_q[1] - vld_cyc_q[0]), 32'(ACKTO + 1));
            check("retry_period2", 32'(vld_cyc_q[2] - vld_cyc_q[1]), 32'(ACKTO + 1));
        end

        // Reset mid-retry: outputs clear next cycle and nothing more is sent
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        n = vld_cyc_q.size();
        repeat (3 * (ACKTO + 1)) @(posedge clk);
        @(negedge clk);
        check("no_vld_after_reset", 32'(vld_cyc_q.size()), 32'(n));
        check("idle_after_reset", 32'(bus.arb_busy), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
